// File: rtl/ramb_dp_mixed_param_if.sv
// rtl/ramb_dp_mixed_param_if.sv - port bundle for the mixed-width dual-port block RAM
//
// Purpose: carries both RAM ports plus status flags. The master modport belongs to the
// user of the RAM; the slave modport belongs to the RAM itself.
// Signals:
//   ENA/ENB        port enable
//   WEA/WEB        write enable (qualified by EN)
//   SSRA/SSRB      synchronous output set/reset (qualified by EN)
//   ADDRA/ADDRB    word address, AW_x bits
//   DIA/DIB        write data, WIDTH_x bits
//   DOA/DOB        read data, WIDTH_x bits
//   BUSY           clear sweep in progress
//   COLLISION      one-cycle pulse after both ports wrote overlapping bits
interface ramb_dp_mixed_param_if #(
  parameter int AW_A    = 14,
  parameter int AW_B    = 10,
  parameter int WIDTH_A = 1,
  parameter int WIDTH_B = 16
);
  logic               ENA;
  logic               WEA;
  logic               SSRA;
  logic [AW_A-1:0]    ADDRA;
  logic [WIDTH_A-1:0] DIA;
  logic [WIDTH_A-1:0] DOA;
  logic               ENB;
  logic               WEB;
  logic               SSRB;
  logic [AW_B-1:0]    ADDRB;
  logic [WIDTH_B-1:0] DIB;
  logic [WIDTH_B-1:0] DOB;
  logic               BUSY;
  logic               COLLISION;

  modport master (
    output ENA, WEA, SSRA, ADDRA, DIA,
    output ENB, WEB, SSRB, ADDRB, DIB,
    input  DOA, DOB, BUSY, COLLISION
  );

  modport slave (
    input  ENA, WEA, SSRA, ADDRA, DIA,
    input  ENB, WEB, SSRB, ADDRB, DIB,
    output DOA, DOB, BUSY, COLLISION
  );
endinterface

// File: rtl/ramb_dp_mixed_param.sv
// rtl/ramb_dp_mixed_param.sv - single-clock true-dual-port block RAM with asymmetric ports
//
// Purpose: MEM_BITS of storage seen as WIDTH_A-bit words on port A and WIDTH_B-bit words
// on port B. Per-port write mode, optional output register and SSR value; optional
// zero sweep after reset; port A wins overlapping bits when both ports write.
// Ports:
//   CLK    single clock for both ports
//   RST_N  asynchronous active-low reset (output stages and control only, not the array)
//   bus    ramb_dp_mixed_param_if.slave carrying both ports, BUSY and COLLISION
module ramb_dp_mixed_param #(
  parameter int                 MEM_BITS       = 16384,
  parameter int                 WIDTH_A        = 1,
  parameter int                 WIDTH_B        = 16,
  parameter string              WRITE_MODE_A   = "WRITE_FIRST",
  parameter string              WRITE_MODE_B   = "WRITE_FIRST",
  parameter int                 DO_REG_A       = 0,
  parameter int                 DO_REG_B       = 0,
  parameter logic [WIDTH_A-1:0] SRVAL_A        = '0,
  parameter logic [WIDTH_B-1:0] SRVAL_B        = '0,
  parameter int                 CLEAR_ON_RESET = 0
) (
  input logic                   CLK,
  input logic                   RST_N,
  ramb_dp_mixed_param_if.slave  bus
);

  localparam int AW_A = $clog2(MEM_BITS / WIDTH_A);
  localparam int AW_B = $clog2(MEM_BITS / WIDTH_B);
  // Storage is organised as 32-bit slices; every port word lies inside exactly one slice.
  localparam int NSL  = MEM_BITS / 32;
  localparam int SW   = $clog2(NSL);
  localparam int LRA  = $clog2(32 / WIDTH_A);
  localparam int LRB  = $clog2(32 / WIDTH_B);
  localparam int LWA  = $clog2(WIDTH_A);
  localparam int LWB  = $clog2(WIDTH_B);

  // Write mode codes: 0 write-first, 1 read-first, 2 no-change, 3 illegal.
  localparam int MA = (WRITE_MODE_A == "WRITE_FIRST") ? 0 :
                      (WRITE_MODE_A == "READ_FIRST")  ? 1 :
                      (WRITE_MODE_A == "NO_CHANGE")   ? 2 : 3;
  localparam int MB = (WRITE_MODE_B == "WRITE_FIRST") ? 0 :
                      (WRITE_MODE_B == "READ_FIRST")  ? 1 :
                      (WRITE_MODE_B == "NO_CHANGE")   ? 2 : 3;

  generate
    if (MA == 3) begin : g_bad_mode_a
      $error("ramb_dp_mixed_param: illegal WRITE_MODE_A");
    end
    if (MB == 3) begin : g_bad_mode_b
      $error("ramb_dp_mixed_param: illegal WRITE_MODE_B");
    end
  endgenerate

  typedef enum logic {CLEAR, READY} state_t;

  logic [31:0]        mem [NSL];
  state_t             state;
  logic [SW-1:0]      clr_cnt;
  logic               busy_q;
  logic               collision_q;

  logic [SW-1:0]      sl_a, sl_b;
  logic [4:0]         off_a, off_b;
  logic [31:0]        msk_a, msk_b, dsh_a, dsh_b;
  logic [31:0]        wa_base, wa_new, wb_new;
  logic               act_a, act_b, wr_a, wr_b, same;
  logic [WIDTH_A-1:0] rd_a, s1_a, s1n_a, do_a;
  logic [WIDTH_B-1:0] rd_b, s1_b, s1n_b, do_b;

  // Address decode: slice index from the upper bits, bit offset from the lower bits.
  assign sl_a  = SW'(bus.ADDRA >> LRA);
  assign sl_b  = SW'(bus.ADDRB >> LRB);
  assign off_a = 5'((bus.ADDRA & AW_A'(32 / WIDTH_A - 1)) << LWA);
  assign off_b = 5'((bus.ADDRB & AW_B'(32 / WIDTH_B - 1)) << LWB);
  assign msk_a = 32'({WIDTH_A{1'b1}}) << off_a;
  assign msk_b = 32'({WIDTH_B{1'b1}}) << off_b;
  assign dsh_a = 32'(bus.DIA) << off_a;
  assign dsh_b = 32'(bus.DIB) << off_b;

  // Reads see the array before this edge's writes, which gives old-data cross-port reads.
  assign rd_a = WIDTH_A'(mem[sl_a] >> off_a);
  assign rd_b = WIDTH_B'(mem[sl_b] >> off_b);

  assign act_a = bus.ENA && (state == READY) && RST_N;
  assign act_b = bus.ENB && (state == READY) && RST_N;
  assign wr_a  = act_a && bus.WEA;
  assign wr_b  = act_b && bus.WEB;
  assign same  = (sl_a == sl_b);

  // When both ports hit one slice, B's merge is applied first and A's on top, so A wins
  // the overlapping bits while B's other bits still land; a single write then commits it.
  assign wb_new  = (mem[sl_b] & ~msk_b) | (dsh_b & msk_b);
  assign wa_base = (wr_b && same) ? wb_new : mem[sl_a];
  assign wa_new  = (wa_base & ~msk_a) | (dsh_a & msk_a);

  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr_b && !(wr_a && same)) mem[sl_b] <= wb_new;
      if (wr_a)                    mem[sl_a] <= wa_new;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      busy_q      <= (CLEAR_ON_RESET != 0);
      clr_cnt     <= '0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= wr_a && wr_b && same && (|(msk_a & msk_b));
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + SW'(1);
          if (clr_cnt == SW'(NSL - 1)) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read stage next value per write mode; no-change keeps the stage on a write.
  always_comb begin
    s1n_a = s1_a;
    if (!bus.WEA || MA == 1) s1n_a = rd_a;
    else if (MA == 0)        s1n_a = bus.DIA;
  end

  always_comb begin
    s1n_b = s1_b;
    if (!bus.WEB || MB == 1) s1n_b = rd_b;
    else if (MB == 0)        s1n_b = bus.DIB;
  end

  // Without the output register the read stage is the output, so SSR must land in it
  // too; otherwise a later no-change write would resurrect the pre-SSR value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_a <= SRVAL_A;
      do_a <= SRVAL_A;
    end else if (act_a) begin
      s1_a <= (DO_REG_A == 0 && bus.SSRA) ? SRVAL_A : s1n_a;
      do_a <= bus.SSRA ? SRVAL_A : ((DO_REG_A != 0) ? s1_a : s1n_a);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_b <= SRVAL_B;
      do_b <= SRVAL_B;
    end else if (act_b) begin
      s1_b <= (DO_REG_B == 0 && bus.SSRB) ? SRVAL_B : s1n_b;
      do_b <= bus.SSRB ? SRVAL_B : ((DO_REG_B != 0) ? s1_b : s1n_b);
    end
  end

  assign bus.DOA       = do_a;
  assign bus.DOB       = do_b;
  assign bus.BUSY      = busy_q;
  assign bus.COLLISION = collision_q;

endmodule
